// File: rtl/eager_fanout_fork.sv
// eager_fanout_fork: one-deep eager fork of a valid/ready stream to NUM_OUT branches with per-branch pending tracking.
// Optional stall counter port stall_cnt is built only when FANOUT_STALL_CNT_EN is defined.
module eager_fanout_fork #(
  parameter int NUM_OUT    = 7,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [NUM_OUT-1:0]    cfg_en,
  input  logic [NUM_OUT-1:0]    cfg_sel,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [NUM_OUT-1:0]    out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic [NUM_OUT-1:0]    out_ready
`ifdef FANOUT_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);
  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;
  state_t state, state_n;
  logic [NUM_OUT-1:0] pend, pend_n, act, waiting;
  logic [DATA_WIDTH-1:0] data_q;
  logic tok_v, last, load;
  assign act      = cfg_en & cfg_sel;
  assign tok_v    = state == HOLD;
  assign waiting  = pend & ~out_ready;
  assign last     = tok_v & (waiting == '0);
  assign in_ready = ~flush & (~tok_v | last);
  assign load     = in_valid & in_ready & (act != '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= EMPTY;
      pend   <= '0;
      data_q <= '0;
    end else begin
      state  <= state_n;
      pend   <= pend_n;
      if (load) data_q <= in_data;
    end
  // flush dominates; a retiring token can be replaced in the same cycle
  always_comb begin
    state_n = flush ? EMPTY : load ? HOLD : last ? EMPTY : state;
    pend_n  = flush ? '0 : load ? act : last ? '0 : waiting;
  end
  always_comb begin
    out_valid = tok_v ? pend : '0;
    out_data  = data_q;
  end
`ifdef FANOUT_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (tok_v && waiting != '0 && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_eager_fanout_fork.sv
// tb_eager_fanout_fork: directed and random checks of eager_fanout_fork against a token/remaining-set model.
// Stall counter checks are included when FANOUT_STALL_CNT_EN is defined.
module tb_eager_fanout_fork;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_ready;
  logic [6:0] cfg_en = 0, cfg_sel = 0, out_valid, out_ready = 0;
  logic [15:0] in_data = 0, out_data;
  int checks = 0, failures = 0;
  logic [6:0] ov;
  logic [15:0] od;
  logic ir;
  bit m_v;
  logic [6:0] m_rem;
  logic [15:0] m_d;
  longint m_stall;
`ifdef FANOUT_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  eager_fanout_fork #(.NUM_OUT(7), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cfg_en(cfg_en), .cfg_sel(cfg_sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef FANOUT_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_v = 0; m_rem = 0; m_d = 0; m_stall = 0;
  endtask
  // one clock: drive inputs, compare against the model, then advance the model
  task automatic step(input logic iv, input logic [15:0] d, input logic [6:0] en, input logic [6:0] sel,
                      input logic [6:0] rdy, input logic fl);
    logic [6:0] act, rem;
    logic exp_ir;
    in_valid = iv; in_data = d; cfg_en = en; cfg_sel = sel; out_ready = rdy; flush = fl;
    @(negedge clk);
    ov = out_valid; od = out_data; ir = in_ready;
    act = en & sel;
    rem = m_v ? (m_rem & ~rdy) : 7'd0;
    exp_ir = !fl && (!m_v || rem == 0);
    chk("out_valid", {25'd0, ov}, {25'd0, m_v ? m_rem : 7'd0});
    chk("in_ready", {31'd0, ir}, {31'd0, exp_ir});
    if (m_v) chk("out_data", {16'd0, od}, {16'd0, m_d});
`ifdef FANOUT_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall[31:0]);
`endif
    if (m_v && rem != 0 && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (fl) begin
      m_v = 0; m_rem = 0;
    end else if (iv && exp_ir && act != 0) begin
      m_v = 1; m_rem = act; m_d = d;
    end else begin
      m_rem = rem;
      if (rem == 0) m_v = 0;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {25'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef FANOUT_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    rst_n = 1;
    step(1, 16'h1234, 7'h7F, 7'h05, 7'h7F, 0);
    step(0, 16'h0000, 7'h7F, 7'h05, 7'h7F, 0);
    chk("t1_ov", {25'd0, ov}, 32'h05);
    chk("t1_od", {16'd0, od}, 32'h1234);
    step(0, 16'h0000, 7'h7F, 7'h05, 7'h7F, 0);
    chk("t1_ov_next", {25'd0, ov}, 32'h00);
    step(1, 16'hAAAA, 7'h7F, 7'h0F, 7'h7F, 0);
    step(0, 0, 7'h7F, 7'h0F, 7'h01, 0);
    chk("t2_ov0", {25'd0, ov}, 32'h0F); chk("t2_ir0", {31'd0, ir}, 32'd0);
    step(0, 0, 7'h7F, 7'h0F, 7'h06, 0);
    chk("t2_ov1", {25'd0, ov}, 32'h0E); chk("t2_ir1", {31'd0, ir}, 32'd0);
    step(0, 0, 7'h7F, 7'h0F, 7'h08, 0);
    chk("t2_ov2", {25'd0, ov}, 32'h08); chk("t2_ir2", {31'd0, ir}, 32'd1);
    step(0, 0, 7'h7F, 7'h0F, 7'h00, 0);
    chk("t2_ov3", {25'd0, ov}, 32'h00);
    for (int i = 1; i <= 9; i++) begin
      step(i <= 8, 16'(i), 7'h7F, 7'h7F, 7'h7F, 0);
      chk("t3_ir", {31'd0, ir}, 32'd1);
      if (i > 1) begin
        chk("t3_ov", {25'd0, ov}, 32'h7F);
        chk("t3_od", {16'd0, od}, 32'(i - 1));
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(i < 3, 16'h0BAD, 7'h7F, 7'h00, 7'h7F, 0);
      chk("t4_ir", {31'd0, ir}, 32'd1);
      chk("t4_ov", {25'd0, ov}, 32'd0);
    end
    step(1, 16'h5555, 7'h7F, 7'h03, 7'h00, 0);
    step(1, 16'h6666, 7'h7F, 7'h03, 7'h00, 1);
    chk("t5_flush_ir", {31'd0, ir}, 32'd0);
    chk("t5_flush_ov", {25'd0, ov}, 32'h03);
    step(0, 0, 7'h7F, 7'h03, 7'h00, 0);
    chk("t5_after_flush_ov", {25'd0, ov}, 32'd0);
    step(1, 16'h7777, 7'h7F, 7'h03, 7'h00, 0);
    step(0, 0, 7'h7F, 7'h03, 7'h00, 0);
    #2 rst_n = 0;
    #1;
    chk("t5_async_ov", {25'd0, out_valid}, 32'd0);
    chk("t5_async_od", {16'd0, out_data}, 32'd0);
    chk("t5_async_ir", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    step(1, 16'h0101, 7'h7F, 7'h03, 7'h00, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 7'h7F, 7'h03, 7'h00, 0);
    step(0, 0, 7'h7F, 7'h03, 7'h03, 0);
    step(0, 0, 7'h7F, 7'h03, 7'h7F, 0);
    chk("t6_idle_ov", {25'd0, ov}, 32'd0);
`ifdef FANOUT_STALL_CNT_EN
    chk("t6_stall_cnt", stall_cnt, 32'd5);
`endif
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 16'($urandom), 7'($urandom),
           ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom),
           ($urandom_range(0, 3) == 0) ? 7'h7F : 7'($urandom),
           $urandom_range(0, 19) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
